host_dma_cmd_splitter: RTL and testbench

- Sits directly upstream of the SoC DMA wrapper, between the PsPIN command unit and the DMA engine.
- Takes one host DMA command of arbitrary length and splits it into sub-commands. Each sub-command is no larger than MaxChunkBytes and never crosses a BoundaryBytes-aligned host address boundary (PCIe rule).
- Issues the sub-commands downstream, each tagged with a slot index, and counts completions per slot.
- Returns exactly one completion per original command, carrying the original cmd_id.

---
 rtl/host_dma_cmd_splitter.sv | 196 +++++++++++++++++++
 tb/tb_host_dma_cmd_splitter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_dma_cmd_splitter.sv
// Splits host DMA commands into chunk- and boundary-limited sub-commands, tracks
// per-slot outstanding sub-commands and returns one completion per original command.
module host_dma_cmd_splitter #(
    parameter int unsigned NumSlots      = 8,
    parameter int unsigned MaxChunkBytes = 1024,
    parameter int unsigned BoundaryBytes = 4096,
    parameter int unsigned CmdIdWidth    = 8,
    parameter int unsigned LenWidth      = 20,
    localparam int unsigned TagW         = $clog2(NumSlots)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [CmdIdWidth-1:0] cmd_id_i,
    input  logic [31:0]           cmd_nic_addr_i,
    input  logic [63:0]           cmd_host_addr_i,
    input  logic [LenWidth-1:0]   cmd_len_i,
    input  logic                  cmd_nic_to_host_i,
    output logic                  sub_valid_o,
    input  logic                  sub_ready_i,
    output logic [TagW-1:0]       sub_tag_o,
    output logic [31:0]           sub_nic_addr_o,
    output logic [63:0]           sub_host_addr_o,
    output logic [LenWidth-1:0]   sub_len_o,
    output logic                  sub_nic_to_host_o,
    input  logic                  sub_rsp_valid_i,
    input  logic [TagW-1:0]       sub_rsp_tag_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [CmdIdWidth-1:0] rsp_cmd_id_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned CntW = LenWidth + 1;
    localparam int unsigned BndW = $clog2(BoundaryBytes);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [NumSlots-1:0]   busy_q, issued_q;
    logic [CntW-1:0]       cnt_q [NumSlots];
    logic [CmdIdWidth-1:0] id_q  [NumSlots];
    logic [TagW-1:0]       cur_slot_q;
    logic [31:0]           nic_q;
    logic [63:0]           host_q;
    logic [LenWidth-1:0]   rem_q;
    logic                  dir_q;
    logic                  rsp_valid_q;
    logic [TagW-1:0]       rsp_slot_q;
    logic [CmdIdWidth-1:0] rsp_id_q;
    logic                  err_q;

    logic                  free_any, done_any;
    logic [TagW-1:0]       free_idx, done_idx;
    logic [NumSlots-1:0]   done_vec;
    logic [LenWidth-1:0]   to_bnd, chunk;
    logic                  cmd_fire, issue_fire, rsp_fire, last_chunk;
    logic                  inc_on_tag, rsp_bad;

    // Lowest free slot and lowest done slot
    always_comb begin
        free_idx = '0;
        done_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            done_vec[i] = busy_q[i] && issued_q[i] && (cnt_q[i] == '0);
            if (!busy_q[i]) free_idx = TagW'(i);
            if (done_vec[i]) done_idx = TagW'(i);
        end
        free_any = ~&busy_q;
        done_any = |done_vec;
    end

    // Chunk is limited by remaining length, max chunk and distance to the next boundary
    always_comb begin
        to_bnd = LenWidth'(BoundaryBytes) - LenWidth'(host_q[BndW-1:0]);
        chunk  = rem_q;
        if (chunk > LenWidth'(MaxChunkBytes)) chunk = LenWidth'(MaxChunkBytes);
        if (chunk > to_bnd) chunk = to_bnd;
    end

    assign cmd_ready_o = free_any && (state_q == ST_IDLE);
    assign sub_valid_o = (state_q == ST_SPLIT);
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign issue_fire  = sub_valid_o && sub_ready_i;
    assign rsp_fire    = rsp_valid_q && rsp_ready_i;
    assign last_chunk  = (rem_q == chunk);

    // A completion is only legal on a busy slot with something outstanding
    assign inc_on_tag = issue_fire && (cur_slot_q == sub_rsp_tag_i);
    assign rsp_bad    = sub_rsp_valid_i &&
                        (!busy_q[sub_rsp_tag_i] || ((cnt_q[sub_rsp_tag_i] == '0) && !inc_on_tag));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_fire && (cmd_len_i != '0)) state_d = ST_SPLIT;
            ST_SPLIT: if (issue_fire && last_chunk)      state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Split datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_slot_q <= '0;
            nic_q      <= '0;
            host_q     <= '0;
            rem_q      <= '0;
            dir_q      <= 1'b0;
        end else if (cmd_fire) begin
            cur_slot_q <= free_idx;
            nic_q      <= cmd_nic_addr_i;
            host_q     <= cmd_host_addr_i;
            rem_q      <= cmd_len_i;
            dir_q      <= cmd_nic_to_host_i;
        end else if (issue_fire) begin
            nic_q  <= nic_q + 32'(chunk);
            host_q <= host_q + 64'(chunk);
            rem_q  <= rem_q - chunk;
        end
    end

    // Per-slot bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= '0;
            issued_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                cnt_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (cmd_fire && (free_idx == TagW'(i))) begin
                    busy_q[i]   <= 1'b1;
                    issued_q[i] <= (cmd_len_i == '0);
                    cnt_q[i]    <= '0;
                    id_q[i]     <= cmd_id_i;
                end else begin
                    if (issue_fire && (cur_slot_q == TagW'(i)) &&
                        !(sub_rsp_valid_i && !rsp_bad && (sub_rsp_tag_i == TagW'(i))))
                        cnt_q[i] <= cnt_q[i] + CntW'(1);
                    else if (sub_rsp_valid_i && !rsp_bad && (sub_rsp_tag_i == TagW'(i)) &&
                             !(issue_fire && (cur_slot_q == TagW'(i))))
                        cnt_q[i] <= cnt_q[i] - CntW'(1);
                    if (issue_fire && last_chunk && (cur_slot_q == TagW'(i)))
                        issued_q[i] <= 1'b1;
                    if (rsp_fire && (rsp_slot_q == TagW'(i))) begin
                        busy_q[i]   <= 1'b0;
                        issued_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Completion selection is locked while the response is stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_slot_q  <= '0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            if (!rsp_valid_q) begin
                if (done_any) begin
                    rsp_valid_q <= 1'b1;
                    rsp_slot_q  <= done_idx;
                    rsp_id_q    <= id_q[done_idx];
                end
            end else if (rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
            if (rsp_bad) err_q <= 1'b1;
        end
    end

    assign sub_tag_o         = cur_slot_q;
    assign sub_nic_addr_o    = nic_q;
    assign sub_host_addr_o   = host_q;
    assign sub_len_o         = chunk;
    assign sub_nic_to_host_o = dir_q;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_cmd_id_o      = rsp_id_q;
    assign busy_o            = |busy_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_host_dma_cmd_splitter.sv
// Directed self-checking bench for host_dma_cmd_splitter.
module tb_host_dma_cmd_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_id = '0;
    logic [31:0] cmd_nic = '0;
    logic [63:0] cmd_host = '0;
    logic [19:0] cmd_len = '0;
    logic        cmd_dir = 1'b0;
    logic        sub_valid;
    logic        sub_ready = 1'b1;
    logic [2:0]  sub_tag;
    logic [31:0] sub_nic;
    logic [63:0] sub_host;
    logic [19:0] sub_len;
    logic        sub_dir;
    logic        sub_rsp_valid = 1'b0;
    logic [2:0]  sub_rsp_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_id;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic        rand_en = 1'b0;
    logic        ready_fixed = 1'b1;
    logic        stab_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_host = '0;
    logic [63:0] prev_nl = '0;

    logic [63:0] sq_host [$];
    logic [31:0] sq_nic  [$];
    logic [19:0] sq_len  [$];
    logic [2:0]  sq_tag  [$];
    logic [7:0]  rq_id   [$];

    host_dma_cmd_splitter dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_id_i          (cmd_id),
        .cmd_nic_addr_i    (cmd_nic),
        .cmd_host_addr_i   (cmd_host),
        .cmd_len_i         (cmd_len),
        .cmd_nic_to_host_i (cmd_dir),
        .sub_valid_o       (sub_valid),
        .sub_ready_i       (sub_ready),
        .sub_tag_o         (sub_tag),
        .sub_nic_addr_o    (sub_nic),
        .sub_host_addr_o   (sub_host),
        .sub_len_o         (sub_len),
        .sub_nic_to_host_o (sub_dir),
        .sub_rsp_valid_i   (sub_rsp_valid),
        .sub_rsp_tag_i     (sub_rsp_tag),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_cmd_id_o      (rsp_id),
        .busy_o            (busy),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake recorders
    always @(posedge clk) begin
        if (rst_n && sub_valid && sub_ready) begin
            sq_host.push_back(sub_host);
            sq_nic.push_back(sub_nic);
            sq_len.push_back(sub_len);
            sq_tag.push_back(sub_tag);
        end
        if (rst_n && rsp_valid && rsp_ready) rq_id.push_back(rsp_id);
    end

    // Downstream ready driver: fixed or random
    always @(posedge clk) begin
        #1;
        sub_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Stalled sub-command must hold its fields
    always @(posedge clk) begin
        if (stab_en && prev_stall) begin
            chk("stall_valid", 64'(sub_valid), 64'd1);
            chk("stall_host", sub_host, prev_host);
            chk("stall_nic_len", {12'd0, sub_nic, sub_len}, prev_nl);
        end
        prev_stall = sub_valid && !sub_ready;
        prev_host  = sub_host;
        prev_nl    = {12'd0, sub_nic, sub_len};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [7:0] id, input logic [31:0] nic,
                            input logic [63:0] host, input logic [19:0] len);
        int k;
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_nic   = nic;
        cmd_host  = host;
        cmd_len   = len;
        cmd_dir   = 1'b1;
        k = 0;
        while (!cmd_ready && k < 300) begin
            tick(1);
            k++;
        end
        if (k >= 300) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [2:0] tag);
        sub_rsp_valid = 1'b1;
        sub_rsp_tag   = tag;
        tick(1);
        sub_rsp_valid = 1'b0;
    endtask

    task automatic wait_subs(input int n);
        int k = 0;
        while (sq_host.size() < n && k < 300) begin
            tick(1);
            k++;
        end
        chk("sub_count", 64'(sq_host.size()), 64'(n));
    endtask

    task automatic wait_rsps(input int n);
        int k = 0;
        while (rq_id.size() < n && k < 300) begin
            tick(1);
            k++;
        end
        chk("rsp_count", 64'(rq_id.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sb;
        int rb;
        logic [2:0] order [8];

        // Reset
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_sub_valid", 64'(sub_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // Single command split into 1024/1024/952
        send_cmd(8'h11, 32'h100, 64'h1000, 20'd3000);
        chk("t1_first_valid", 64'(sub_valid), 64'd1);
        chk("t1_first_tag", 64'(sub_tag), 64'd0);
        wait_subs(3);
        chk("t1_len0", 64'(sq_len[0]), 64'd1024);
        chk("t1_len1", 64'(sq_len[1]), 64'd1024);
        chk("t1_len2", 64'(sq_len[2]), 64'd952);
        chk("t1_host0", sq_host[0], 64'h1000);
        chk("t1_host1", sq_host[1], 64'h1400);
        chk("t1_host2", sq_host[2], 64'h1800);
        chk("t1_nic2", 64'(sq_nic[2]), 64'h900);
        chk("t1_tag2", 64'(sq_tag[2]), 64'd0);
        send_rsp(3'd0);
        send_rsp(3'd0);
        tick(3);
        chk("t1_no_early_rsp", 64'(rq_id.size()), 64'd0);
        send_rsp(3'd0);
        wait_rsps(1);
        chk("t1_rsp_id", 64'(rq_id[0]), 64'h11);
        tick(2);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // Boundary crossing
        send_cmd(8'h22, 32'h2000, 64'h0F00, 20'd512);
        wait_subs(5);
        chk("t2_len0", 64'(sq_len[3]), 64'd256);
        chk("t2_host0", sq_host[3], 64'h0F00);
        chk("t2_len1", 64'(sq_len[4]), 64'd256);
        chk("t2_host1", sq_host[4], 64'h1000);
        chk("t2_nic1", 64'(sq_nic[4]), 64'h2100);
        send_rsp(3'd0);
        send_rsp(3'd0);
        wait_rsps(2);
        chk("t2_rsp_id", 64'(rq_id[1]), 64'h22);
        tick(2);

        // Zero length
        sb = sq_host.size();
        send_cmd(8'h5A, 32'h0, 64'h0, 20'd0);
        chk("t3_no_sub", 64'(sub_valid), 64'd0);
        chk("t3_rsp_not_yet", 64'(rsp_valid), 64'd0);
        tick(1);
        chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t3_rsp_id", 64'(rsp_id), 64'h5A);
        wait_rsps(3);
        tick(2);
        chk("t3_sub_none", 64'(sq_host.size()), 64'(sb));

        // Full: eight commands with completions withheld
        for (int i = 0; i < 8; i++) send_cmd(8'h30 + 8'(i), 32'h0, 64'(i) * 64'h100, 20'd64);
        wait_subs(sb + 8);
        tick(2);
        chk("t4_full_ready", 64'(cmd_ready), 64'd0);
        chk("t4_full_busy", 64'(busy), 64'd1);
        chk("t4_tag7", 64'(sq_tag[sb + 7]), 64'd7);
        rsp_ready = 1'b0;
        send_rsp(3'd3);
        tick(2);
        chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t4_rsp_id", 64'(rsp_id), 64'h33);
        chk("t4_ready_while_freeing", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b1;
        tick(1);
        chk("t4_ready_after_free", 64'(cmd_ready), 64'd1);
        send_cmd(8'h77, 32'h0, 64'h40, 20'd64);
        wait_subs(sb + 9);
        chk("t4_reuse_tag", 64'(sq_tag[sb + 8]), 64'd3);
        rb = rq_id.size();
        order = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
        for (int i = 0; i < 8; i++) begin
            send_rsp(order[i]);
            tick(3);
        end
        wait_rsps(rb + 8);
        chk("t4_last_id", 64'(rq_id[rb + 7]), 64'h77);
        chk("t4_drained", 64'(busy), 64'd0);

        // Backpressure and out-of-order completion
        sb = sq_host.size();
        rb = rq_id.size();
        stab_en = 1'b1;
        rand_en = 1'b1;
        for (int i = 0; i < 3; i++) send_cmd(8'hA0 + 8'(i), 32'h0, 64'h0, 20'd2048);
        wait_subs(sb + 6);
        rand_en = 1'b0;
        tick(2);
        stab_en = 1'b0;
        chk("t5_tag1", 64'(sq_tag[sb + 1]), 64'd0);
        chk("t5_tag3", 64'(sq_tag[sb + 3]), 64'd1);
        chk("t5_tag5", 64'(sq_tag[sb + 5]), 64'd2);
        chk("t5_len5", 64'(sq_len[sb + 5]), 64'd1024);
        chk("t5_host5", sq_host[sb + 5], 64'h400);
        send_rsp(3'd2); send_rsp(3'd2); tick(4);
        send_rsp(3'd0); send_rsp(3'd0); tick(4);
        send_rsp(3'd1); send_rsp(3'd1);
        wait_rsps(rb + 3);
        chk("t5_ord0", 64'(rq_id[rb]), 64'hA2);
        chk("t5_ord1", 64'(rq_id[rb + 1]), 64'hA0);
        chk("t5_ord2", 64'(rq_id[rb + 2]), 64'hA1);

        // Held response
        rsp_ready = 1'b0;
        send_cmd(8'hB5, 32'h0, 64'h0, 20'd0);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t6_hold_id", 64'(rsp_id), 64'hB5);
            tick(1);
        end
        rsp_ready = 1'b1;
        wait_rsps(rb + 4);
        chk("t6_rsp_id", 64'(rq_id[rb + 3]), 64'hB5);

        // Error: completion on a free slot
        tick(2);
        chk("t7_err_before", 64'(err), 64'd0);
        send_cmd(8'hC0, 32'h0, 64'h0, 20'd2048);
        wait_subs(sb + 8);
        send_rsp(3'd6);
        chk("t7_err_set", 64'(err), 64'd1);
        send_rsp(3'd0);
        tick(3);
        chk("t7_no_rsp_yet", 64'(rq_id.size()), 64'(rb + 4));
        send_rsp(3'd0);
        wait_rsps(rb + 5);
        chk("t7_rsp_id", 64'(rq_id[rb + 4]), 64'hC0);
        tick(2);
        chk("t7_err_sticky", 64'(err), 64'd1);
        chk("t7_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
